register_bank_p: RTL and testbench
==================================

# register_bank_p

Parametrised register bank: the next-generation successor to the fixed 7-entry × 65-bit enable-register bank in the FactoCore datapath. It holds DEPTH entries of WIDTH bits and provides two write modes: addressed and append (auto-incrementing pointer). It tracks a valid bit per entry with an occupancy count. It has two independent read ports with 1-cycle registered latency and write-through bypass. The FactoCore controller uses it to store operands and partial products, and can flush it with one clear pulse.

## Interface
- WIDTH, 65, entry width in bits
- DEPTH, 7, number of entries (≥2)
- AW (localparam), $clog2(DEPTH), address width
- CW (localparam), $clog2(DEPTH+1), count / pointer width
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous reset, active-high
- clr  in  1  flush: clear all valid bits, count and append pointer
- wr_en  in  1  write request
- wr_mode  in  1  0 = addressed write, 1 = append write
- wr_addr  in  AW  target entry (addressed mode only)
- wr_data  in  WIDTH  write data
- wr_err  out  1  registered pulse: the previous cycle's write was rejected
- rd_en_a / rd_en_b  in  1  read request, ports A/B
- rd_addr_a / rd_addr_b  in  AW  read address
- rd_data_a / rd_data_b  out  WIDTH  registered read data
- rd_hit_a / rd_hit_b  out  1  addressed entry was valid, address in range
- vld  out  DEPTH  per-entry valid bits
- count  out  CW  number of valid entries
- full  out  1  append pointer == DEPTH

## Operation
- Addressed write (wr_en=1, wr_mode=0):
  - wr_addr < DEPTH: the entry takes wr_data and vld[wr_addr] is set.
  - count increments only if the entry was previously invalid.
  - wr_addr ≥ DEPTH: no state change; wr_err=1 next cycle.
- Append write (wr_en=1, wr_mode=1):
  - wr_ptr < DEPTH: entry[wr_ptr] takes wr_data and its valid bit is set. wr_ptr increments by 1.
  - count increments only if the entry was previously invalid.
  - full (wr_ptr == DEPTH): no state change; wr_err=1 next cycle. The pointer never wraps.
- Read:
  - On rd_en, rd_data takes the entry value and rd_hit takes vld & (addr < DEPTH).
  - Out-of-range address: rd_data=0, rd_hit=0.
  - When rd_en=0, rd_data and rd_hit hold their previous values.
- Bypass: a read to the same entry as an accepted write in the same cycle returns wr_data with rd_hit=1. This applies to both ports.
- Clear (clr=1):
  - Next cycle: vld=0, count=0, wr_ptr=0.
  - Entry data is not zeroed.
  - clr has priority over a same-cycle write. The write is dropped with no wr_err.
  - A same-cycle read returns the pre-clear data and the pre-clear hit.
- Priority, highest first: reset > clr > write.

## Timing
- Reset values (cycle after reset sampled high):
  - Entries, vld, count, wr_ptr: 0.
  - full, wr_err, rd_data_a/b, rd_hit_a/b: 0.
- Reset asserted mid-operation discards any same-cycle write or read.
- Write to visibility:
  - vld, count and full reflect a write on the next edge.
  - A read issued the cycle after a write returns the new data.
- Read latency: exactly 1 cycle, registered outputs.
- wr_err is a single-cycle pulse aligned with the cycle after the rejected request.
- vld, count and full are flop outputs; no combinational path from inputs.

## Structure
- Shared package (factocore_pkg):
  - WR_ADDRESSED / WR_APPEND mode constants.
  - Default WIDTH (65) and DEPTH (7) constants.
- Sub-module register_r_en_p:
  - Parameters: WIDTH.
  - Ports: clk, reset, en, d, q.
  - Synchronous active-high reset.
  - Instantiated DEPTH times in a generate loop for the entry storage.
- Valid bits, count, pointer, error and read-port logic live in the top module.

## Test plan
- Reset, then addressed writes of 0x1_0000_0000_0000_00AA to addr 3 and 0x55 to addr 3 -> vld=7'b0001000, count=1; read A addr 3 one cycle later gives 0x55, rd_hit_a=1.
- Seven appends of data 1..7 with DEPTH=7 -> full=1, count=7, entry k holds k+1. An eighth append -> wr_err pulses 1 cycle; all state unchanged.
- Same-cycle addressed write of 0x1234 to addr 2 with read A/B both at addr 2 -> next cycle rd_data_a=rd_data_b=0x1234, both hits=1.
- After a fill, clr and an append in the same cycle -> vld=0, count=0, full=0, wr_ptr=0, wr_err=0. A read of addr 0 then returns the old data with rd_hit=0.
- Out-of-range addr 7 (DEPTH=7): a write -> wr_err=1, no change; a read -> rd_data=0, rd_hit=0.
- reset asserted in the middle of an append burst -> every output is 0 next cycle. Re-parametrise to WIDTH=32, DEPTH=16 and repeat the fill/full check.

Source files
------------

// File: rtl/factocore_pkg.sv
// Shared FactoCore constants: write-mode encodings and default bank geometry.
// Imported by register_bank_p and its storage sub-module.
package factocore_pkg;

  localparam logic WR_ADDRESSED = 1'b0;
  localparam logic WR_APPEND    = 1'b1;

  localparam int DEF_WIDTH = 65;
  localparam int DEF_DEPTH = 7;

endpackage

// File: rtl/register_r_en_p.sv
// Enabled WIDTH-bit register with synchronous active-high reset.
// Ports: clk, reset, en (load strobe), d (next value), q (stored value).
module register_r_en_p
  import factocore_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_bank_p.sv
// DEPTH x WIDTH register bank: addressed/append writes, valid tracking,
// two registered read ports with write-through bypass, one-pulse flush.
// Ports: clk, reset, clr, wr_* (write req), wr_err, rd_*_a/b, vld, count, full.
module register_bank_p
  import factocore_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             wr_mode,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_err,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  output logic             rd_hit_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_hit_b,
  output logic [DEPTH-1:0] vld,
  output logic [CW-1:0]    count,
  output logic             full
);

  logic [WIDTH-1:0] ent [DEPTH];
  logic [CW-1:0]    wr_ptr;
  logic [CW-1:0]    ptr_nx;
  logic             acc;
  logic             rej;
  logic [AW-1:0]    tgt;
  logic [DEPTH-1:0] wmask;
  logic [WIDTH:0]   rd_nx_a;
  logic [WIDTH:0]   rd_nx_b;

  assign ptr_nx = wr_ptr + CW'(1);

  // A write is accepted only when in range and not overridden by clr.
  always_comb begin
    acc = 1'b0;
    tgt = wr_addr;
    if (wr_en && !clr) begin
      if (wr_mode == WR_APPEND) begin
        acc = (wr_ptr < CW'(DEPTH));
        tgt = wr_ptr[AW-1:0];
      end else begin
        acc = (32'(wr_addr) < DEPTH);
      end
    end
    rej = wr_en && !clr && !acc;
  end

  always_comb begin
    wmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wmask[i] = acc && (tgt == AW'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    register_r_en_p #(.WIDTH(WIDTH)) u_reg (
      .clk  (clk),
      .reset(reset),
      .en   (wmask[g]),
      .d    (wr_data),
      .q    (ent[g])
    );
  end

  // Returns {hit, data}; out-of-range addresses match no entry.
  function automatic logic [WIDTH:0] rd_lookup(input logic [AW-1:0] addr);
    logic [WIDTH:0] r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == AW'(i)) r = {vld[i], ent[i]};
    end
    if (acc && (addr == tgt)) r = {1'b1, wr_data};
    return r;
  endfunction

  always_comb begin
    rd_nx_a = rd_lookup(rd_addr_a);
    rd_nx_b = rd_lookup(rd_addr_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      full      <= 1'b0;
      wr_err    <= 1'b0;
      rd_data_a <= '0;
      rd_hit_a  <= 1'b0;
      rd_data_b <= '0;
      rd_hit_b  <= 1'b0;
    end else begin
      wr_err <= rej;
      if (clr) begin
        vld    <= '0;
        count  <= '0;
        wr_ptr <= '0;
        full   <= 1'b0;
      end else begin
        vld <= vld | wmask;
        if (|(wmask & ~vld)) count <= count + CW'(1);
        if (acc && (wr_mode == WR_APPEND)) begin
          wr_ptr <= ptr_nx;
          full   <= (ptr_nx == CW'(DEPTH));
        end
      end
      if (rd_en_a) {rd_hit_a, rd_data_a} <= rd_nx_a;
      if (rd_en_b) {rd_hit_b, rd_data_b} <= rd_nx_b;
    end
  end

endmodule

// File: tb/tb_register_bank_p.sv
// Self-checking bench for register_bank_p (7x65 and 16x32 instances).
// Read expectations go through per-port scoreboard queues.
module tb_register_bank_p;

  localparam int W1 = 65;
  localparam int D1 = 7;
  localparam int A1 = 3;
  localparam int C1 = 3;
  localparam int W2 = 32;
  localparam int D2 = 16;
  localparam int A2 = 4;
  localparam int C2 = 5;

  typedef struct {
    logic [W1-1:0] d;
    logic          h;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          clr = 0, wr_en = 0, wr_mode = 0;
  logic [A1-1:0] wr_addr = '0;
  logic [W1-1:0] wr_data = '0;
  logic          wr_err;
  logic          rd_en_a = 0, rd_en_b = 0;
  logic [A1-1:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [W1-1:0] rd_data_a, rd_data_b;
  logic          rd_hit_a, rd_hit_b;
  logic [D1-1:0] vld;
  logic [C1-1:0] count;
  logic          full;

  logic          clr2 = 0, wr_en2 = 0, wr_mode2 = 0;
  logic [A2-1:0] wr_addr2 = '0;
  logic [W2-1:0] wr_data2 = '0;
  logic          wr_err2;
  logic          rd_en_a2 = 0, rd_en_b2 = 0;
  logic [A2-1:0] rd_addr_a2 = '0, rd_addr_b2 = '0;
  logic [W2-1:0] rd_data_a2, rd_data_b2;
  logic          rd_hit_a2, rd_hit_b2;
  logic [D2-1:0] vld2;
  logic [C2-1:0] count2;
  logic          full2;

  register_bank_p #(.WIDTH(W1), .DEPTH(D1)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_err(wr_err),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a), .rd_hit_a(rd_hit_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b), .rd_hit_b(rd_hit_b),
    .vld(vld), .count(count), .full(full)
  );

  register_bank_p #(.WIDTH(W2), .DEPTH(D2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr2),
    .wr_en(wr_en2), .wr_mode(wr_mode2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .wr_err(wr_err2),
    .rd_en_a(rd_en_a2), .rd_addr_a(rd_addr_a2),
    .rd_data_a(rd_data_a2), .rd_hit_a(rd_hit_a2),
    .rd_en_b(rd_en_b2), .rd_addr_b(rd_addr_b2),
    .rd_data_b(rd_data_b2), .rd_hit_b(rd_hit_b2),
    .vld(vld2), .count(count2), .full(full2)
  );

  int checks = 0;
  int passed = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t e;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; rd_en_a = 0; rd_en_b = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    step();
    reset = 0;
    checks++;
    if ({vld, count, full, wr_err} !== '0) $display("FAIL reset_ctl vld=%b cnt=%0d full=%b err=%b req 0", vld, count, full, wr_err);
    else passed++;
    checks++;
    if ({rd_data_a, rd_hit_a, rd_data_b, rd_hit_b} !== '0) $display("FAIL reset_rd a=%h/%b b=%h/%b req 0", rd_data_a, rd_hit_a, rd_data_b, rd_hit_b);
    else passed++;
    checks++;
    if ({vld2, count2, full2, wr_err2} !== '0) $display("FAIL reset_ctl2 vld=%b cnt=%0d req 0", vld2, count2);
    else passed++;
  endtask

  task automatic test_addressed();
    wr_en = 1; wr_mode = 0; wr_addr = 3;
    wr_data = 65'h1_0000_0000_0000_00AA;
    step();
    wr_data = 65'h55;
    step();
    wr_en = 0;
    checks++;
    if (vld !== 7'b0001000 || count !== 3'd1) $display("FAIL addr_vld vld=%b cnt=%0d req 0001000/1", vld, count);
    else passed++;
    rd_en_a = 1; rd_addr_a = 3; qa.push_back('{d: 65'h55, h: 1'b1});
    rd_en_b = 1; rd_addr_b = 4; qb.push_back('{d: '0, h: 1'b0});
    step();
    idle();
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL addr_rd_a got %h/%b req %h/%b", rd_data_a, rd_hit_a, e.d, e.h);
    else passed++;
    e = qb.pop_front();
    checks++;
    if (rd_data_b !== e.d || rd_hit_b !== e.h) $display("FAIL addr_rd_b got %h/%b req %h/%b", rd_data_b, rd_hit_b, e.d, e.h);
    else passed++;
  endtask

  task automatic test_append();
    clr = 1;
    step();
    clr = 0;
    wr_en = 1; wr_mode = 1;
    for (int k = 0; k < D1; k++) begin
      wr_data = W1'(k + 1);
      step();
    end
    wr_en = 0;
    checks++;
    if (full !== 1'b1 || count !== 3'd7 || vld !== 7'h7f || wr_err !== 1'b0) $display("FAIL fill full=%b cnt=%0d vld=%b err=%b req 1/7/1111111/0", full, count, vld, wr_err);
    else passed++;
    for (int k = 0; k < D1; k++) begin
      rd_en_a = 1; rd_addr_a = A1'(k);
      qa.push_back('{d: W1'(k + 1), h: 1'b1});
      step();
      e = qa.pop_front();
      checks++;
      if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL fill_rd%0d got %h/%b req %h/%b", k, rd_data_a, rd_hit_a, e.d, e.h);
      else passed++;
    end
    rd_en_a = 0;
    wr_en = 1; wr_mode = 1; wr_data = 65'h99;
    step();
    wr_en = 0;
    checks++;
    if (wr_err !== 1'b1 || count !== 3'd7 || full !== 1'b1 || vld !== 7'h7f) $display("FAIL over_err err=%b cnt=%0d full=%b req 1/7/1", wr_err, count, full);
    else passed++;
    step();
    checks++;
    if (wr_err !== 1'b0) $display("FAIL err_pulse got %b req 0", wr_err);
    else passed++;
    wr_en = 1; wr_mode = 0; wr_addr = 1; wr_data = 65'h22;
    step();
    wr_en = 0;
    checks++;
    if (count !== 3'd7 || wr_err !== 1'b0) $display("FAIL rewrite_cnt cnt=%0d err=%b req 7/0", count, wr_err);
    else passed++;
    rd_en_a = 1; rd_addr_a = 0; qa.push_back('{d: 65'h1, h: 1'b1});
    step();
    rd_en_a = 0;
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL over_keep got %h/%b req %h/%b", rd_data_a, rd_hit_a, e.d, e.h);
    else passed++;
  endtask

  task automatic test_bypass();
    wr_en = 1; wr_mode = 0; wr_addr = 2; wr_data = 65'h1234;
    rd_en_a = 1; rd_addr_a = 2; qa.push_back('{d: 65'h1234, h: 1'b1});
    rd_en_b = 1; rd_addr_b = 2; qb.push_back('{d: 65'h1234, h: 1'b1});
    step();
    idle();
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL byp_a got %h/%b req %h/%b", rd_data_a, rd_hit_a, e.d, e.h);
    else passed++;
    e = qb.pop_front();
    checks++;
    if (rd_data_b !== e.d || rd_hit_b !== e.h) $display("FAIL byp_b got %h/%b req %h/%b", rd_data_b, rd_hit_b, e.d, e.h);
    else passed++;
  endtask

  task automatic test_clear();
    clr = 1;
    wr_en = 1; wr_mode = 1; wr_data = 65'hBEEF;
    rd_en_a = 1; rd_addr_a = 0; qa.push_back('{d: 65'h1, h: 1'b1});
    step();
    idle();
    checks++;
    if ({vld, count, full, wr_err} !== '0) $display("FAIL clr_ctl vld=%b cnt=%0d full=%b err=%b req 0", vld, count, full, wr_err);
    else passed++;
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL clr_rd_pre got %h/%b req %h/%b", rd_data_a, rd_hit_a, e.d, e.h);
    else passed++;
    rd_en_a = 1; rd_addr_a = 0; qa.push_back('{d: 65'h1, h: 1'b0});
    step();
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h) $display("FAIL clr_rd_post got %h/%b req %h/%b", rd_data_a, rd_hit_a, e.d, e.h);
    else passed++;
    rd_en_a = 0;
    wr_en = 1; wr_mode = 1; wr_data = 65'h77;
    step();
    wr_en = 0;
    rd_en_a = 1; rd_addr_a = 0; qa.push_back('{d: 65'h77, h: 1'b1});
    step();
    rd_en_a = 0;
    e = qa.pop_front();
    checks++;
    if (rd_data_a !== e.d || rd_hit_a !== e.h || count !== 3'd1 || vld !== 7'b1) $display("FAIL clr_ptr got %h/%b cnt=%0d req %h/%b/1", rd_data_a, rd_hit_a, count, e.d, e.h);
    else passed++;
  endtask

  task automatic test_out_of_range();
    wr_en = 1; wr_mode = 0; wr_addr = 7; wr_data = 65'h5;
    rd_en_b = 1; rd_addr_b = 7; qb.push_back('{d: '0, h: 1'b0});
    step();
    idle();
    checks++;
    if (wr_err !== 1'b1 || count !== 3'd1 || vld !== 7'b1) $display("FAIL oor_wr err=%b cnt=%0d vld=%b req 1/1/0000001", wr_err, count, vld);
    else passed++;
    e = qb.pop_front();
    checks++;
    if (rd_data_b !== e.d || rd_hit_b !== e.h) $display("FAIL oor_rd got %h/%b req %h/%b", rd_data_b, rd_hit_b, e.d, e.h);
    else passed++;
    rd_addr_a = 4;
    step();
    checks++;
    if (rd_data_a !== 65'h77 || rd_hit_a !== 1'b1) $display("FAIL rd_hold got %h/%b req 77/1", rd_data_a, rd_hit_a);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clr = 1;
    step();
    clr = 0;
    wr_en = 1; wr_mode = 1; wr_data = 65'hA;
    step();
    step();
    reset = 1;
    rd_en_a = 1; rd_addr_a = 0;
    rd_en_b = 1; rd_addr_b = 1;
    step();
    reset = 0;
    idle();
    checks++;
    if ({vld, count, full, wr_err} !== '0) $display("FAIL mid_rst_ctl vld=%b cnt=%0d full=%b err=%b req 0", vld, count, full, wr_err);
    else passed++;
    checks++;
    if ({rd_data_a, rd_hit_a, rd_data_b, rd_hit_b} !== '0) $display("FAIL mid_rst_rd a=%h/%b b=%h/%b req 0", rd_data_a, rd_hit_a, rd_data_b, rd_hit_b);
    else passed++;
  endtask

  task automatic test_param2();
    logic [W2-1:0] exp2[$];
    logic [W2-1:0] x;
    wr_en2 = 1; wr_mode2 = 1;
    for (int k = 0; k < D2; k++) begin
      wr_data2 = W2'(32'hC000 + k);
      step();
      if (k == D2 - 2) begin
        checks++;
        if (full2 !== 1'b0 || count2 !== 5'd15) $display("FAIL p2_nearfull full=%b cnt=%0d req 0/15", full2, count2);
        else passed++;
      end
    end
    wr_en2 = 0;
    checks++;
    if (full2 !== 1'b1 || count2 !== 5'd16 || vld2 !== 16'hffff) $display("FAIL p2_full full=%b cnt=%0d vld=%h req 1/16/ffff", full2, count2, vld2);
    else passed++;
    wr_en2 = 1; wr_data2 = 32'hDEAD;
    step();
    wr_en2 = 0;
    checks++;
    if (wr_err2 !== 1'b1 || count2 !== 5'd16) $display("FAIL p2_over err=%b cnt=%0d req 1/16", wr_err2, count2);
    else passed++;
    rd_en_b2 = 1; rd_addr_b2 = 15; exp2.push_back(32'hC00F);
    step();
    rd_en_b2 = 0;
    x = exp2.pop_front();
    checks++;
    if (rd_data_b2 !== x || rd_hit_b2 !== 1'b1) $display("FAIL p2_rd15 got %h/%b req %h/1", rd_data_b2, rd_hit_b2, x);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_append();
    test_bypass();
    test_clear();
    test_out_of_range();
    test_reset_mid();
    test_param2();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
